// File: rtl/assign_1.sv
// Serial bit-pattern detector: flags one cycle after the last PAT_LEN samples of d equal PATTERN.
// alarm is a plain flop output; a fill counter blocks matches against reset contents of the history.
module assign_1 #(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1110
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic alarm
);

    localparam int unsigned FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               alarm_q, alarm_d;

    // Oldest sample sits in the MSB so the history lines up directly with PATTERN.
    generate
        if (PAT_LEN == 1) begin : g_hist_one
            always_comb hist_d = d;
        end else begin : g_hist_many
            always_comb hist_d = {hist_q[PAT_LEN-2:0], d};
        end
    endgenerate

    always_comb begin
        fill_d  = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
        alarm_d = (hist_d == PATTERN) && (fill_d == FILL_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            alarm_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;

endmodule

// File: tb/tb_assign_1.sv
// Directed bench for assign_1: default "1110" detector and a PATTERN=0000 instance
// sharing clock, reset and serial input.
module tb_assign_1;

    logic clk;
    logic reset;
    logic d;
    logic alarm_def;
    logic alarm_zero;

    int tests_run;
    int tests_failed;

    assign_1 #(
        .PAT_LEN (4),
        .PATTERN (4'b1110)
    ) u_def (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .alarm (alarm_def)
    );

    assign_1 #(
        .PAT_LEN (4),
        .PATTERN (4'b0000)
    ) u_zero (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .alarm (alarm_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive d away from the edge, then sample just after the edge that captures it.
    task automatic step(input logic dv);
        @(negedge clk);
        d = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic dv);
        @(negedge clk);
        reset = 1'b1;
        d = dv;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            tests_run++;
            if (alarm_def !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold_def[%0d]: got %b want 0", i, alarm_def);
            end
            tests_run++;
            if (alarm_zero !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold_zero[%0d]: got %b want 0", i, alarm_zero);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            tests_run++;
            if (alarm_def !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_zeros_def[%0d]: got %b want 0", i, alarm_def);
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] seq;
        logic [5:0] exp;
        seq = 6'b111000;
        exp = 6'b000100;
        apply_reset(1'b1);
        for (int i = 5; i >= 0; i--) begin
            step(seq[i]);
            tests_run++;
            if (alarm_def !== exp[i]) begin
                tests_failed++;
                $display("FAIL basic[%0d]: got %b want %b", 5 - i, alarm_def, exp[i]);
            end
        end
    endtask

    task automatic test_long_ones();
        logic [5:0] seq;
        logic [5:0] exp;
        seq = 6'b111110;
        exp = 6'b000001;
        apply_reset(1'b0);
        for (int i = 5; i >= 0; i--) begin
            step(seq[i]);
            tests_run++;
            if (alarm_def !== exp[i]) begin
                tests_failed++;
                $display("FAIL long_ones[%0d]: got %b want %b", 5 - i, alarm_def, exp[i]);
            end
        end
    endtask

    task automatic test_partial();
        logic [6:0] seq;
        logic [6:0] exp;
        seq = 7'b1101110;
        exp = 7'b0000001;
        apply_reset(1'b0);
        for (int i = 6; i >= 0; i--) begin
            step(seq[i]);
            tests_run++;
            if (alarm_def !== exp[i]) begin
                tests_failed++;
                $display("FAIL partial[%0d]: got %b want %b", 6 - i, alarm_def, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq;
        logic [3:0] exp;
        apply_reset(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        apply_reset(1'b1);
        tests_run++;
        if (alarm_def !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_edge: got %b want 0", alarm_def);
        end
        step(1'b0);
        tests_run++;
        if (alarm_def !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_zero: got %b want 0", alarm_def);
        end
        seq = 4'b1110;
        exp = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            step(seq[i]);
            tests_run++;
            if (alarm_def !== exp[i]) begin
                tests_failed++;
                $display("FAIL reset_mid_rerun[%0d]: got %b want %b", 3 - i, alarm_def, exp[i]);
            end
        end
    endtask

    task automatic test_zero_pattern();
        logic [6:0] seq;
        logic [6:0] exp;
        seq = 7'b0000010;
        exp = 7'b0001100;
        apply_reset(1'b0);
        for (int i = 6; i >= 0; i--) begin
            step(seq[i]);
            tests_run++;
            if (alarm_zero !== exp[i]) begin
                tests_failed++;
                $display("FAIL zero_pattern[%0d]: got %b want %b", 6 - i, alarm_zero, exp[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        d            = 1'b0;
        test_reset();
        test_basic();
        test_long_ones();
        test_partial();
        test_reset_mid();
        test_zero_pattern();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
